// File: rtl/spi_slave_responder.sv
// SPI responder end of the wrapper link.
// - Receives 10-bit {cmd, payload} frames on MOSI, MSB first.
// - Hands each complete frame to the RAM side with a one-cycle valid pulse.
// - For read-data commands (cmd = all ones), waits for the RAM's byte and
//   shifts it back out on MISO, MSB first.
// One SPI bit is transferred per clock cycle; everything runs on the
// rising clock edge.
module spi_slave_responder #(
  parameter int CMD_W  = 2,
  parameter int DATA_W = 8
) (
  input  logic                      i_spi_slave_clk,
  input  logic                      i_spi_slave_rst,
  input  logic                      i_spi_slave_ss_n,
  input  logic                      i_spi_slave_mosi,
  output logic                      o_spi_slave_miso,
  output logic [CMD_W+DATA_W-1:0]   o_spi_slave_rx_data,
  output logic                      o_spi_slave_rx_valid,
  input  logic [DATA_W-1:0]         i_spi_slave_tx_data,
  input  logic                      i_spi_slave_tx_valid,
  output logic                      o_spi_slave_frame_err,
  output logic                      o_spi_slave_busy
);

  localparam int FRM_W = CMD_W + DATA_W;
  localparam int BCW   = $clog2(FRM_W + 1);
  localparam int TCW   = $clog2(DATA_W + 1);
  localparam logic [CMD_W-1:0] CMD_RD = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_WAIT_TX,
    S_TX,
    S_HOLD
  } state_t;

  state_t             state_q,     state_d;
  logic [FRM_W-2:0]   rx_sh_q,     rx_sh_d;
  logic [BCW-1:0]     bit_cnt_q,   bit_cnt_d;
  logic [FRM_W-1:0]   rx_data_q,   rx_data_d;
  logic               rx_valid_q,  rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic [DATA_W-1:0]  tx_sh_q,     tx_sh_d;
  logic [TCW-1:0]     tx_cnt_q,    tx_cnt_d;
  logic               miso_q,      miso_d;

  // Frame as it would look if the current MOSI bit were the last one.
  logic [FRM_W-1:0]   frame_w;
  logic [CMD_W-1:0]   frame_cmd_w;

  assign frame_w     = {rx_sh_q, i_spi_slave_mosi};
  assign frame_cmd_w = frame_w[FRM_W-1 -: CMD_W];

  // State and datapath registers; synchronous reset returns everything to idle.
  always_ff @(posedge i_spi_slave_clk) begin
    if (i_spi_slave_rst) begin
      state_q     <= S_IDLE;
      rx_sh_q     <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_sh_q     <= '0;
      tx_cnt_q    <= '0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_sh_q     <= rx_sh_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      tx_sh_q     <= tx_sh_d;
      tx_cnt_q    <= tx_cnt_d;
      miso_q      <= miso_d;
    end
  end

  // Next-state logic. Pulses and MISO default low so they only assert when
  // explicitly driven in the current state.
  always_comb begin
    state_d     = state_q;
    rx_sh_d     = rx_sh_q;
    bit_cnt_d   = bit_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    tx_sh_d     = tx_sh_q;
    tx_cnt_d    = tx_cnt_q;
    miso_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The first selected edge already carries the frame MSB.
        if (!i_spi_slave_ss_n) begin
          rx_sh_d   = {{(FRM_W-2){1'b0}}, i_spi_slave_mosi};
          bit_cnt_d = BCW'(1);
          state_d   = S_RX;
        end
      end

      S_RX: begin
        if (i_spi_slave_ss_n) begin
          // Master gave up mid-frame: drop the partial frame, keep old rx_data.
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = S_IDLE;
        end else if (bit_cnt_q == BCW'(FRM_W - 1)) begin
          rx_data_d  = frame_w;
          rx_valid_d = 1'b1;
          rx_sh_d    = frame_w[FRM_W-2:0];
          bit_cnt_d  = '0;
          state_d    = (frame_cmd_w == CMD_RD) ? S_WAIT_TX : S_HOLD;
        end else begin
          rx_sh_d   = frame_w[FRM_W-2:0];
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end

      S_WAIT_TX: begin
        // No timeout: the RAM may take as long as it needs while selected.
        if (i_spi_slave_ss_n) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else if (i_spi_slave_tx_valid) begin
          miso_d   = i_spi_slave_tx_data[DATA_W-1];
          tx_sh_d  = {i_spi_slave_tx_data[DATA_W-2:0], 1'b0};
          tx_cnt_d = TCW'(1);
          state_d  = S_TX;
        end
      end

      S_TX: begin
        // tx_cnt counts bits already on MISO; the MSB went out on entry.
        if (i_spi_slave_ss_n) begin
          frame_err_d = 1'b1;
          tx_cnt_d    = '0;
          state_d     = S_IDLE;
        end else if (tx_cnt_q == TCW'(DATA_W)) begin
          tx_cnt_d = '0;
          state_d  = S_HOLD;
        end else begin
          miso_d   = tx_sh_q[DATA_W-1];
          tx_sh_d  = {tx_sh_q[DATA_W-2:0], 1'b0};
          tx_cnt_d = tx_cnt_q + TCW'(1);
        end
      end

      S_HOLD: begin
        // Frame done; ignore anything until the master deselects.
        if (i_spi_slave_ss_n) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_spi_slave_miso      = miso_q;
  assign o_spi_slave_rx_data   = rx_data_q;
  assign o_spi_slave_rx_valid  = rx_valid_q;
  assign o_spi_slave_frame_err = frame_err_q;
  assign o_spi_slave_busy      = (state_q != S_IDLE);

endmodule
